// File: rtl/mb_ser_lanes_if.sv
// Record-side and beat-side signals of the lane serializer.
// master = serializer view, slave = FIFO / downstream view.
interface mb_ser_lanes_if #(
  parameter int MAX_N = 64,
  parameter int POS_W = 6,
  parameter int LANES = 2
);
  localparam int SIZE_W = $clog2(MAX_N) + 1;

  // Record side: mb_rd pops one record while mb_empty is low; the record
  // fields are valid in the cycle after mb_rd and held until the next pop.
  // Beat side: out_wr qualifies lane_vld/sign_out/pos_out/last_out for one
  // cycle; any of dese_full/pos_afull/bit_prog_full withholds the next beat.
  logic [MAX_N-1:0]       sign_in;
  logic [MAX_N*POS_W-1:0] pos_in;
  logic [SIZE_W-1:0]      size_in;
  logic                   slice_end;
  logic                   no_sign;
  logic                   mb_empty;
  logic                   mb_rd;

  logic                   dese_full;
  logic                   pos_afull;
  logic                   bit_prog_full;

  logic                   out_wr;
  logic [LANES-1:0]       lane_vld;
  logic [LANES-1:0]       sign_out;
  logic [LANES*POS_W-1:0] pos_out;
  logic [LANES-1:0]       last_out;
  logic                   slice_end_out;

  modport master (
    input  sign_in, pos_in, size_in, slice_end, no_sign, mb_empty,
    input  dese_full, pos_afull, bit_prog_full,
    output mb_rd,
    output out_wr, lane_vld, sign_out, pos_out, last_out, slice_end_out
  );

  modport slave (
    output sign_in, pos_in, size_in, slice_end, no_sign, mb_empty,
    output dese_full, pos_afull, bit_prog_full,
    input  mb_rd,
    input  out_wr, lane_vld, sign_out, pos_out, last_out, slice_end_out
  );
endinterface

// File: rtl/mb_ser_lanes.sv
// Macroblock serializer: pops one record per FIFO read and streams its (sign, pos)
// entries LANES per beat, oldest first, prefetching the next record on the final beat.
module mb_ser_lanes #(
  parameter int MAX_N = 64,
  parameter int POS_W = 6,
  parameter int LANES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  output logic [1:0]     state_dbg,
  mb_ser_lanes_if.master bus
);
  localparam int SIZE_W = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDLAT = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                 state;
  logic [SIZE_W-1:0]      rem;
  logic                   se_reg;
  logic [MAX_N-1:0]       sign_sr;
  logic [MAX_N*POS_W-1:0] pos_sr;

  logic                   stall;
  logic                   beat_ok;
  logic                   final_beat;
  logic                   empty_rec;
  logic [SIZE_W-1:0]      n_clamp;
  logic [SIZE_W-1:0]      k;
  logic [LANES-1:0]       vld_mask;
  logic [LANES-1:0]       last_mask;
  logic [LANES-1:0]       lane_sign;
  logic [LANES*POS_W-1:0] lane_pos;

  assign state_dbg  = state;
  assign stall      = bus.dese_full | bus.pos_afull | bus.bit_prog_full;
  assign beat_ok    = clk_en & ~stall & (state == SHIFT);
  assign n_clamp    = (bus.size_in > SIZE_W'(MAX_N)) ? SIZE_W'(MAX_N) : bus.size_in;
  assign empty_rec  = bus.no_sign | (n_clamp == '0);
  assign k          = (rem < SIZE_W'(LANES)) ? rem : SIZE_W'(LANES);
  assign final_beat = (rem <= SIZE_W'(LANES));

  // Oldest remaining entry sits at the top of the shift registers and maps to lane 0.
  always_comb begin
    vld_mask  = '0;
    last_mask = '0;
    lane_sign = '0;
    lane_pos  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sign[i]               = sign_sr[MAX_N-1-i];
      lane_pos[i*POS_W +: POS_W] = pos_sr[(MAX_N-1-i)*POS_W +: POS_W];
      vld_mask[i]                = (SIZE_W'(i) < k);
      last_mask[i]               = final_beat && (SIZE_W'(i + 1) == k);
    end
  end

  // Pop in IDLE, or on the final beat so the next record lands with no idle state.
  always_comb begin
    bus.mb_rd = 1'b0;
    case (state)
      IDLE:    bus.mb_rd = clk_en & ~bus.mb_empty;
      SHIFT:   bus.mb_rd = beat_ok & final_beat & ~bus.mb_empty;
      default: bus.mb_rd = 1'b0;
    endcase
  end

  // Shifting by a full LANES on the final beat is harmless: the next load overwrites.
  always_ff @(posedge clk) begin
    if (clk_en && state == RDLAT) begin
      sign_sr <= bus.sign_in;
      pos_sr  <= bus.pos_in;
    end else if (beat_ok) begin
      sign_sr <= sign_sr << LANES;
      pos_sr  <= pos_sr << (LANES * POS_W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      rem               <= '0;
      se_reg            <= 1'b0;
      bus.out_wr        <= 1'b0;
      bus.lane_vld      <= '0;
      bus.sign_out      <= '0;
      bus.pos_out       <= '0;
      bus.last_out      <= '0;
      bus.slice_end_out <= 1'b0;
    end else begin
      bus.out_wr        <= 1'b0;
      bus.lane_vld      <= '0;
      bus.last_out      <= '0;
      bus.slice_end_out <= 1'b0;
      if (clk_en) begin
        case (state)
          IDLE: begin
            if (bus.mb_rd) state <= RDLAT;
          end
          RDLAT: begin
            if (empty_rec) begin
              bus.slice_end_out <= bus.slice_end;
              state             <= IDLE;
            end else begin
              rem    <= n_clamp;
              se_reg <= bus.slice_end;
              state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (!stall) begin
              bus.out_wr   <= 1'b1;
              bus.lane_vld <= vld_mask;
              bus.sign_out <= lane_sign;
              bus.pos_out  <= lane_pos;
              bus.last_out <= last_mask;
              rem          <= rem - k;
              if (final_beat) begin
                bus.slice_end_out <= se_reg;
                se_reg            <= 1'b0;
                state             <= bus.mb_rd ? RDLAT : IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mb_ser_lanes.sv
// Bench for mb_ser_lanes: FIFO model feeding records, entry-level scoreboard,
// directed timing steps followed by a randomized stress section.
module tb_mb_ser_lanes;
  localparam int MAX_N  = 64;
  localparam int POS_W  = 6;
  localparam int LANES  = 2;
  localparam int SIZE_W = $clog2(MAX_N) + 1;
  localparam int EW     = POS_W + 2;
  localparam int MAXC   = 20000;

  typedef struct {
    logic [MAX_N-1:0]       sign;
    logic [MAX_N*POS_W-1:0] pos;
    logic [SIZE_W-1:0]      size;
    logic                   se;
    logic                   ns;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [1:0] state_dbg;

  mb_ser_lanes_if #(.MAX_N(MAX_N), .POS_W(POS_W), .LANES(LANES)) bus ();

  mb_ser_lanes #(.MAX_N(MAX_N), .POS_W(POS_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .state_dbg (state_dbg),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  rec_t          rec_q[$];
  logic [EW-1:0] exp_q[$];   // {last, sign, pos} per entry, oldest first
  logic [1:0]    blk_q[$];   // {empty_block, slice_end} per observable block
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic                   wr_log[MAXC];
  logic                   rd_log[MAXC];
  logic                   se_log[MAXC];
  logic [LANES-1:0]       vld_log[MAXC];
  logic [LANES-1:0]       last_log[MAXC];
  logic [LANES*POS_W-1:0] pos_log[MAXC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rec(input int size, input bit se, input bit ns, input int base);
    rec_t r;
    r.sign = {$urandom, $urandom};
    for (int j = 0; j < MAX_N; j++)
      r.pos[(MAX_N-1-j)*POS_W +: POS_W] = (base < 0) ? POS_W'($urandom_range(0, 63)) : POS_W'(base + j);
    r.size = SIZE_W'(size);
    r.se   = se;
    r.ns   = ns;
    rec_q.push_back(r);
    bus.mb_empty = 1'b0;
  endtask

  // FIFO pop: present the record and append the entries it must produce.
  task automatic fifo_pop();
    rec_t r;
    int   n;
    r = rec_q.pop_front();
    bus.sign_in   = r.sign;
    bus.pos_in    = r.pos;
    bus.size_in   = r.size;
    bus.slice_end = r.se;
    bus.no_sign   = r.ns;
    bus.mb_empty  = (rec_q.size() == 0);
    n = (int'(r.size) > MAX_N) ? MAX_N : int'(r.size);
    if (r.ns || n == 0) begin
      if (r.se) blk_q.push_back(2'b11);
    end else begin
      for (int j = 0; j < n; j++)
        exp_q.push_back({(j == n - 1), r.sign[MAX_N-1-j], r.pos[(MAX_N-1-j)*POS_W +: POS_W]});
      blk_q.push_back({1'b0, r.se});
    end
  endtask

  task automatic tick();
    logic          rd_now;
    logic          saw_last;
    logic [EW-1:0] e;
    logic [1:0]    b;
    int            k;
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: observed=%0d expected_below=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    wr_log[cyc]   = bus.out_wr;
    rd_log[cyc]   = bus.mb_rd;
    se_log[cyc]   = bus.slice_end_out;
    vld_log[cyc]  = bus.lane_vld;
    last_log[cyc] = bus.last_out;
    pos_log[cyc]  = bus.pos_out;
    chk("rd_while_empty", 64'(bus.mb_rd & bus.mb_empty), 64'd0);
    if (bus.out_wr) begin
      k = 0;
      saw_last = 1'b0;
      while (k < LANES && k < exp_q.size() && !saw_last) begin
        saw_last = exp_q[k][EW-1];
        k++;
      end
      chk("beat_expected", 64'(k > 0), 64'd1);
      chk("lane_vld", 64'(bus.lane_vld), 64'((1 << k) - 1));
      for (int i = 0; i < LANES; i++) begin
        if (i < k) begin
          e = exp_q.pop_front();
          chk("sign", 64'(bus.sign_out[i]), 64'(e[POS_W]));
          chk("pos", 64'(bus.pos_out[i*POS_W +: POS_W]), 64'(e[POS_W-1:0]));
          chk("last", 64'(bus.last_out[i]), 64'(e[EW-1]));
        end else begin
          chk("last_pad", 64'(bus.last_out[i]), 64'd0);
        end
      end
      if (saw_last) begin
        b = (blk_q.size() > 0) ? blk_q.pop_front() : 2'b10;
        chk("blk_kind", 64'(b[1]), 64'd0);
        chk("slice_end_last", 64'(bus.slice_end_out), 64'(b[0]));
      end else begin
        chk("slice_end_mid", 64'(bus.slice_end_out), 64'd0);
      end
    end else begin
      chk("idle_vld", 64'(bus.lane_vld), 64'd0);
      chk("idle_last", 64'(bus.last_out), 64'd0);
      if (bus.slice_end_out) begin
        b = (blk_q.size() > 0) ? blk_q.pop_front() : 2'b00;
        chk("empty_pulse", 64'(b), 64'd3);
      end
    end
    rd_now = bus.mb_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_now && rst) fifo_pop();
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while (i < budget && (rec_q.size() != 0 || exp_q.size() != 0 || blk_q.size() != 0)) begin
      tick();
      i++;
    end
    chk(tag, 64'(rec_q.size() + exp_q.size() + blk_q.size()), 64'd0);
    tick();
    tick();
  endtask

  function automatic int next_wr(input int from);
    for (int c = from; c < cyc; c++) if (wr_log[c]) return c;
    return MAXC - 8;
  endfunction

  function automatic int next_rd(input int from);
    for (int c = from; c < cyc; c++) if (rd_log[c]) return c;
    return MAXC - 8;
  endfunction

  function automatic int next_last(input int from);
    for (int c = from; c < cyc; c++) if (last_log[c] != '0) return c;
    return MAXC - 8;
  endfunction

  function automatic int count_wr(input int from, input int to);
    int n = 0;
    for (int c = from; c < to && c < cyc; c++) if (wr_log[c]) n++;
    return n;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_wr"}, 64'(bus.out_wr), 64'd0);
    chk({tag, "_lane_vld"}, 64'(bus.lane_vld), 64'd0);
    chk({tag, "_sign_out"}, 64'(bus.sign_out), 64'd0);
    chk({tag, "_pos_out"}, 64'(bus.pos_out), 64'd0);
    chk({tag, "_last_out"}, 64'(bus.last_out), 64'd0);
    chk({tag, "_slice_end"}, 64'(bus.slice_end_out), 64'd0);
    chk({tag, "_mb_rd"}, 64'(bus.mb_rd), 64'd0);
  endtask

  initial begin
    int   t0, c_rd, c1, cl, ca, cb, n_left, sz, sel;
    logic seen;
    for (int c = 0; c < MAXC; c++) begin
      wr_log[c] = 1'b0; rd_log[c] = 1'b0; se_log[c] = 1'b0;
      vld_log[c] = '0; last_log[c] = '0; pos_log[c] = '0;
    end
    bus.sign_in = '0; bus.pos_in = '0; bus.size_in = '0;
    bus.slice_end = 1'b0; bus.no_sign = 1'b0; bus.mb_empty = 1'b1;
    bus.dese_full = 1'b0; bus.pos_afull = 1'b0; bus.bit_prog_full = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    tick();
    tick();
    chk_outputs_zero("reset");
    chk("reset_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    tick();

    // Size 5, pos 10..14: beats 11/11/01, first beat 3 cycles after mb_rd
    t0 = cyc;
    push_rec(5, 1'b0, 1'b0, 10);
    drain("t1_drain", 100);
    c_rd = next_rd(t0);
    c1 = next_wr(c_rd);
    chk("t1_latency", 64'(c1 - c_rd), 64'd3);
    chk("t1_vld0", 64'(vld_log[c1]), 64'd3);
    chk("t1_vld1", 64'(vld_log[c1+1]), 64'd3);
    chk("t1_vld2", 64'(vld_log[c1+2]), 64'd1);
    chk("t1_pos0", 64'(pos_log[c1]), 64'({6'd11, 6'd10}));
    chk("t1_pos1", 64'(pos_log[c1+1]), 64'({6'd13, 6'd12}));
    chk("t1_pos2", 64'(pos_log[c1+2][POS_W-1:0]), 64'd14);
    chk("t1_last", 64'({last_log[c1], last_log[c1+1], last_log[c1+2]}), 64'b000001);
    chk("t1_end", 64'(wr_log[c1+3]), 64'd0);

    // Size 1 with slice_end
    t0 = cyc;
    push_rec(1, 1'b1, 1'b0, 5);
    drain("t2_drain", 100);
    c1 = next_wr(t0);
    chk("t2_vld", 64'(vld_log[c1]), 64'd1);
    chk("t2_last", 64'(last_log[c1]), 64'd1);
    chk("t2_se", 64'(se_log[c1]), 64'd1);
    chk("t2_pos", 64'(pos_log[c1][POS_W-1:0]), 64'd5);
    chk("t2_after", 64'({wr_log[c1+1], se_log[c1+1], last_log[c1+1]}), 64'd0);

    // no_sign with slice_end, then a normal record
    t0 = cyc;
    push_rec(4, 1'b1, 1'b1, 0);
    push_rec(2, 1'b0, 1'b0, 33);
    drain("t3_drain", 100);
    c_rd = next_rd(t0);
    chk("t3_se_early", 64'(se_log[c_rd+1]), 64'd0);
    chk("t3_se_pulse", 64'(se_log[c_rd+2]), 64'd1);
    chk("t3_no_wr", 64'({wr_log[c_rd+1], wr_log[c_rd+2]}), 64'd0);
    chk("t3_next_rd", 64'(next_rd(c_rd + 1) - c_rd), 64'd2);

    // Size 8 with pos_afull for 4 cycles after beat 1
    t0 = cyc;
    push_rec(8, 1'b0, 1'b0, 20);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = wr_log[cyc-1];
    end
    bus.pos_afull = 1'b1;
    repeat (4) tick();
    bus.pos_afull = 1'b0;
    drain("t4a_drain", 100);
    c1 = next_wr(t0);
    cl = next_last(c1);
    chk("t4a_span", 64'(cl - c1), 64'd7);
    chk("t4a_beats", 64'(count_wr(c1, cl + 1)), 64'd4);

    // Same with clk_en low for 3 cycles
    t0 = cyc;
    push_rec(8, 1'b0, 1'b0, 20);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = wr_log[cyc-1];
    end
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    drain("t4b_drain", 100);
    c1 = next_wr(t0);
    cl = next_last(c1);
    chk("t4b_span", 64'(cl - c1), 64'd6);
    chk("t4b_beats", 64'(count_wr(c1, cl + 1)), 64'd4);

    // Back-to-back sizes 2 and 4: prefetch on final beat, one idle cycle
    t0 = cyc;
    push_rec(2, 1'b0, 1'b0, 30);
    push_rec(4, 1'b1, 1'b0, 40);
    drain("t5_drain", 100);
    ca = next_wr(t0);
    chk("t5_prefetch", 64'(rd_log[ca-1]), 64'd1);
    chk("t5_a_vld", 64'(vld_log[ca]), 64'd3);
    chk("t5_a_last", 64'(last_log[ca]), 64'd2);
    cb = next_wr(ca + 1);
    chk("t5_gap", 64'(cb - ca), 64'd2);
    chk("t5_b_pos", 64'(pos_log[cb]), 64'({6'd41, 6'd40}));

    // Size 70 clamps to 64 entries
    t0 = cyc;
    push_rec(70, 1'b1, 1'b0, -1);
    drain("t6_drain", 200);
    chk("t6_beats", 64'(count_wr(t0, cyc)), 64'd32);
    cl = next_last(t0);
    chk("t6_last_vld", 64'(vld_log[cl]), 64'd3);
    chk("t6_last", 64'(last_log[cl]), 64'd2);
    chk("t6_se", 64'(se_log[cl]), 64'd1);

    // Reset mid-block, then a clean record
    t0 = cyc;
    push_rec(20, 1'b0, 1'b0, 0);
    for (int i = 0; i < 60 && count_wr(t0, cyc) < 3; i++) tick();
    #2 rst = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    exp_q.delete();
    blk_q.delete();
    tick();
    tick();
    rst = 1'b1;
    t0 = cyc;
    push_rec(6, 1'b1, 1'b0, 50);
    drain("t7_drain", 100);
    c1 = next_wr(t0);
    chk("t7_first_pos", 64'(pos_log[c1]), 64'({6'd51, 6'd50}));
    chk("t7_latency", 64'(c1 - next_rd(t0)), 64'd3);

    // Randomized records, backpressure and clk_en
    n_left = 40;
    for (int i = 0; i < 6000 && (n_left > 0 || rec_q.size() != 0 || exp_q.size() != 0 || blk_q.size() != 0); i++) begin
      if (n_left > 0 && $urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) sz = 0;
        else if (sel == 1) sz = $urandom_range(60, 70);
        else if (sel == 2) sz = $urandom_range(65, 127);
        else sz = $urandom_range(1, 12);
        push_rec(sz, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), -1);
        n_left--;
      end
      bus.dese_full     = ($urandom_range(0, 7) == 0);
      bus.pos_afull     = ($urandom_range(0, 7) == 0);
      bus.bit_prog_full = ($urandom_range(0, 7) == 0);
      clk_en            = ($urandom_range(0, 9) != 0);
      tick();
    end
    bus.dese_full = 1'b0; bus.pos_afull = 1'b0; bus.bit_prog_full = 1'b0;
    clk_en = 1'b1;
    drain("t8_drain", 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mb_ser_lanes.md
Name: mb_ser_lanes

Overview:
Parametrised successor to the macroblock serializer. It pops one macroblock record per FIFO read: up to MAX_N (sign, pos) entries, a valid count, and slice_end/no_sign flags. It emits the entries LANES per beat, oldest first, towards the deserializer and bit-packer. New capabilities: multi-lane output, empty blocks that still carry slice_end, back-to-back prefetch with no idle state, and size clamping.

Parameters:
MAX_N, 64, maximum entries per macroblock record
POS_W, 6, position field width
LANES, 2, entries emitted per output beat (1..8, must divide MAX_N)
SIZE_W, $clog2(MAX_N)+1, derived width of the size field (not overridden)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, asynchronous, active-low
clk_en  in  1  global enable; when low, all state holds
sign_in  in  MAX_N  entry signs; bit MAX_N-1 is the oldest entry
pos_in  in  MAX_N*POS_W  entry positions; same ordering as sign_in
size_in  in  SIZE_W  valid entry count, counted from the oldest end
slice_end  in  1  record closes a slice
no_sign  in  1  record carries no entries
mb_empty  in  1  record FIFO empty
dese_full, pos_afull, bit_prog_full  in  1 each  downstream backpressure
mb_rd  out  1  FIFO pop (combinational); data valid the following cycle
out_wr  out  1  beat valid
lane_vld  out  LANES  per-lane valid mask
sign_out  out  LANES  per-lane sign
pos_out  out  LANES*POS_W  per-lane position
last_out  out  LANES  set on the lane holding the block's final entry
slice_end_out  out  1  one-cycle slice-end pulse

Behaviour:
- stall = dese_full | pos_afull | bit_prog_full. beat_ok = clk_en & ~stall & (state==SHIFT).
- States:
  - IDLE: mb_rd = clk_en & ~mb_empty; moves to RDLAT when mb_rd is high.
  - RDLAT: record inputs are valid in this cycle and are sampled regardless of stall.
    - n = min(size_in, MAX_N); sizes above MAX_N are clamped.
    - If no_sign or n==0: next state is IDLE; slice_end_out is registered to slice_end (a pulse in the next cycle); out_wr stays 0.
    - Otherwise: load sign/pos shift registers, rem=n, se_reg=slice_end; next state SHIFT.
  - SHIFT: on beat_ok, emit k=min(LANES,rem) entries.
    - Lane i carries the i-th oldest remaining entry; lane_vld = k low bits set.
    - Shift registers advance by k; rem -= k.
    - If rem<=LANES (final beat): last_out[k-1]=1 and slice_end_out=se_reg in the same registered cycle. mb_rd = ~mb_empty in this cycle (prefetch); next state is RDLAT if the read was issued, otherwise IDLE.
- All outputs except mb_rd are registered. out_wr, lane_vld, last_out and slice_end_out are 0 in any cycle without a beat or pulse, including clk_en-low cycles. sign_out and pos_out hold their last values.
- Latency: mb_rd in cycle t gives the first out_wr in cycle t+3. Between consecutive non-stalled blocks there is a 1-cycle out_wr gap (the RDLAT cycle).
- Stall holds the shift registers and rem exactly. No entry is dropped or duplicated.
- mb_rd is never high while mb_empty is high, nor in RDLAT or non-final SHIFT cycles.
- Reset (asynchronous, any cycle, including mid-block): state=IDLE, rem=0, se_reg=0, and every output register is 0. The partial block is discarded. Data shift registers need no reset.

Test Plan:
- LANES=2, record size 5 with pos 10..14 (oldest first), no stall -> three out_wr beats: lane_vld 11, 11, 01; pos (10,11), (12,13), (14,–); last_out=01 on beat 3 only; first beat 3 cycles after mb_rd.
- Size 1, slice_end=1 -> single beat with lane_vld=01, last_out=01, slice_end_out=1 in the same cycle; next cycle all pulses are 0.
- no_sign=1, slice_end=1 -> no out_wr; slice_end_out pulses exactly 2 cycles after mb_rd; the next record is then read.
- Size 8 with pos_afull held high for 4 cycles after beat 1 -> out_wr low for those 4 cycles; the remaining beats carry entries 2..7 in order with none missing or duplicated. Repeat with clk_en low for 3 cycles: identical result.
- Records of size 2 then 4 back-to-back with mb_empty low -> mb_rd high in the first block's final-beat cycle; exactly one idle cycle before the second block's first beat.
- Size 70 -> clamped to 64 entries (32 beats). Assert rst low mid-block -> all outputs 0 immediately; after release the next record is serialized cleanly from entry 0.
